// File: rtl/divergent_scheduler_if.sv
// Handshake bundle between the SIMT core pipeline and the divergent warp scheduler.
// The pipeline side uses the master modport and the scheduler uses the slave modport.
interface divergent_scheduler_if #(
    parameter int unsigned THREADS_PER_BLOCK = 4,
    parameter int unsigned PC_BITS           = 8
);
    localparam int unsigned TcBits = $clog2(THREADS_PER_BLOCK + 1);

    logic                                       start;
    logic [TcBits-1:0]                          thread_count;
    logic                                       decoded_mem_read_enable;
    logic                                       decoded_mem_write_enable;
    logic                                       decoded_ret;
    logic [2:0]                                 fetcher_state;
    logic [THREADS_PER_BLOCK-1:0][1:0]          lsu_state;
    logic [THREADS_PER_BLOCK-1:0][PC_BITS-1:0]  next_pc;
    logic [PC_BITS-1:0]                         current_pc;
    logic [THREADS_PER_BLOCK-1:0]               thread_mask;
    logic [2:0]                                 core_state;
    logic                                       done;

    modport master (
        output start, thread_count, decoded_mem_read_enable, decoded_mem_write_enable,
        output decoded_ret, fetcher_state, lsu_state, next_pc,
        input  current_pc, thread_mask, core_state, done
    );

    modport slave (
        input  start, thread_count, decoded_mem_read_enable, decoded_mem_write_enable,
        input  decoded_ret, fetcher_state, lsu_state, next_pc,
        output current_pc, thread_mask, core_state, done
    );
endinterface

// File: rtl/divergent_scheduler.sv
// Per-block instruction scheduler with per-lane PCs: divergent lanes are serialised and
// reconverge by always issuing the lowest PC among live lanes.
module divergent_scheduler #(
    parameter int unsigned THREADS_PER_BLOCK = 4,
    parameter int unsigned PC_BITS           = 8
) (
    input logic                  clk,
    input logic                  reset,
    divergent_scheduler_if.slave bus
);
    localparam int unsigned TcBits = $clog2(THREADS_PER_BLOCK + 1);

    localparam logic [2:0] FetcherFetched = 3'b010;
    localparam logic [1:0] LsuRequesting  = 2'b01;
    localparam logic [1:0] LsuWaiting     = 2'b10;

    typedef enum logic [2:0] {
        StIdle    = 3'b000,
        StFetch   = 3'b001,
        StDecode  = 3'b010,
        StRequest = 3'b011,
        StWait    = 3'b100,
        StExecute = 3'b101,
        StUpdate  = 3'b110,
        StDone    = 3'b111
    } state_e;

    state_e                                    state_q, state_d;
    logic [PC_BITS-1:0]                        current_pc_q, current_pc_d;
    logic [THREADS_PER_BLOCK-1:0]              thread_mask_q, thread_mask_d;
    logic                                      done_q, done_d;
    logic [THREADS_PER_BLOCK-1:0]              alive_q, alive_d;
    logic [THREADS_PER_BLOCK-1:0][PC_BITS-1:0] thread_pc_q, thread_pc_d;

    // Memory-op decode is informational only; fold it away so it is visibly consumed.
    logic unused_mem_decode;
    assign unused_mem_decode = bus.decoded_mem_read_enable ^ bus.decoded_mem_write_enable;

    logic [TcBits-1:0]                         tc_eff;
    logic [THREADS_PER_BLOCK-1:0]              launch_alive;
    logic                                      lsu_busy;
    logic [THREADS_PER_BLOCK-1:0]              upd_alive;
    logic [THREADS_PER_BLOCK-1:0][PC_BITS-1:0] upd_pc;
    logic [PC_BITS-1:0]                        min_pc;
    logic                                      min_found;
    logic [THREADS_PER_BLOCK-1:0]              min_mask;

    always_comb begin
        tc_eff = (bus.thread_count > TcBits'(THREADS_PER_BLOCK)) ?
                 TcBits'(THREADS_PER_BLOCK) : bus.thread_count;
        launch_alive = '0;
        for (int unsigned i = 0; i < THREADS_PER_BLOCK; i++) begin
            launch_alive[i] = (TcBits'(i) < tc_eff);
        end
    end

    // Only lanes issuing the current instruction can hold the pipeline in WAIT.
    always_comb begin
        lsu_busy = 1'b0;
        for (int unsigned i = 0; i < THREADS_PER_BLOCK; i++) begin
            if (thread_mask_q[i] &&
                (bus.lsu_state[i] == LsuRequesting || bus.lsu_state[i] == LsuWaiting)) begin
                lsu_busy = 1'b1;
            end
        end
    end

    // Post-update lane state and the reconvergence choice derived from it.
    always_comb begin
        upd_alive = alive_q;
        upd_pc    = thread_pc_q;
        for (int unsigned i = 0; i < THREADS_PER_BLOCK; i++) begin
            if (thread_mask_q[i]) begin
                if (bus.decoded_ret) begin
                    upd_alive[i] = 1'b0;
                end else begin
                    upd_pc[i] = bus.next_pc[i];
                end
            end
        end
        min_pc    = '0;
        min_found = 1'b0;
        for (int unsigned i = 0; i < THREADS_PER_BLOCK; i++) begin
            if (upd_alive[i] && (!min_found || upd_pc[i] < min_pc)) begin
                min_pc    = upd_pc[i];
                min_found = 1'b1;
            end
        end
        min_mask = '0;
        for (int unsigned i = 0; i < THREADS_PER_BLOCK; i++) begin
            min_mask[i] = upd_alive[i] && (upd_pc[i] == min_pc);
        end
    end

    always_comb begin
        state_d       = state_q;
        current_pc_d  = current_pc_q;
        thread_mask_d = thread_mask_q;
        done_d        = done_q;
        alive_d       = alive_q;
        thread_pc_d   = thread_pc_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    if (tc_eff == '0) begin
                        state_d       = StDone;
                        done_d        = 1'b1;
                        thread_mask_d = '0;
                    end else begin
                        state_d       = StFetch;
                        alive_d       = launch_alive;
                        thread_pc_d   = '0;
                        current_pc_d  = '0;
                        thread_mask_d = launch_alive;
                    end
                end
            end
            StFetch: begin
                if (bus.fetcher_state == FetcherFetched) begin
                    state_d = StDecode;
                end
            end
            StDecode:  state_d = StRequest;
            StRequest: state_d = StWait;
            StWait: begin
                if (!lsu_busy) begin
                    state_d = StExecute;
                end
            end
            StExecute: state_d = StUpdate;
            StUpdate: begin
                alive_d     = upd_alive;
                thread_pc_d = upd_pc;
                if (!min_found) begin
                    state_d       = StDone;
                    done_d        = 1'b1;
                    thread_mask_d = '0;
                end else begin
                    state_d       = StFetch;
                    current_pc_d  = min_pc;
                    thread_mask_d = min_mask;
                end
            end
            StDone: ;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            current_pc_q  <= '0;
            thread_mask_q <= '0;
            done_q        <= 1'b0;
            alive_q       <= '0;
            thread_pc_q   <= '0;
        end else begin
            state_q       <= state_d;
            current_pc_q  <= current_pc_d;
            thread_mask_q <= thread_mask_d;
            done_q        <= done_d;
            alive_q       <= alive_d;
            thread_pc_q   <= thread_pc_d;
        end
    end

    assign bus.core_state  = state_q;
    assign bus.current_pc  = current_pc_q;
    assign bus.thread_mask = thread_mask_q;
    assign bus.done        = done_q;
endmodule

// File: tb/tb_divergent_scheduler.sv
// Directed bench for divergent_scheduler: launch, divergence/reconvergence, LSU stalls,
// RET retirement, zero-thread launch and reset dominance.
module tb_divergent_scheduler;
    localparam int unsigned T = 4;
    localparam int unsigned P = 8;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [15:0] obs;
    logic [15:0] expv;

    divergent_scheduler_if #(.THREADS_PER_BLOCK(T), .PC_BITS(P)) bus ();

    divergent_scheduler #(.THREADS_PER_BLOCK(T), .PC_BITS(P)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign obs = {bus.core_state, bus.current_pc, bus.thread_mask, bus.done};

    function automatic logic [15:0] pack(input logic [2:0] st, input logic [7:0] pc,
                                         input logic [3:0] m, input logic d);
        return {st, pc, m, d};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [2:0] tc);
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus.thread_count = tc;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic run_instr();
        for (int k = 0; k < 6; k++) step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        expv = pack(3'd0, 8'd0, 4'b0000, 1'b0);
        n_checks++;
        if (obs !== expv) begin n_fail++; $display("FAIL reset_state: got %h want %h", obs, expv); end
        reset = 1'b0;
    endtask

    task automatic test_uniform();
        bus.next_pc = {4{8'd1}};
        launch(3'd4);
        expv = pack(3'd1, 8'd0, 4'b1111, 1'b0);
        n_checks++;
        if (obs !== expv) begin n_fail++; $display("FAIL launch: got %h want %h", obs, expv); end
        for (int s = 2; s <= 6; s++) begin
            step();
            expv = pack(s[2:0], 8'd0, 4'b1111, 1'b0);
            n_checks++;
            if (obs !== expv) begin n_fail++; $display("FAIL pipe_state%0d: got %h want %h", s, obs, expv); end
        end
        step();
        expv = pack(3'd1, 8'd1, 4'b1111, 1'b0);
        n_checks++;
        if (obs !== expv) begin n_fail++; $display("FAIL uniform_next: got %h want %h", obs, expv); end
    endtask

    task automatic test_divergence();
        launch(3'd4);
        bus.next_pc = {8'd9, 8'd5, 8'd9, 8'd5};
        run_instr();
        expv = pack(3'd1, 8'd5, 4'b0101, 1'b0);
        n_checks++;
        if (obs !== expv) begin n_fail++; $display("FAIL diverge: got %h want %h", obs, expv); end
        bus.next_pc = {4{8'd9}};
        run_instr();
        expv = pack(3'd1, 8'd9, 4'b1111, 1'b0);
        n_checks++;
        if (obs !== expv) begin n_fail++; $display("FAIL reconverge: got %h want %h", obs, expv); end
        bus.next_pc = {8'd100, 8'd200, 8'd100, 8'd200};
        run_instr();
        expv = pack(3'd1, 8'd100, 4'b1010, 1'b0);
        n_checks++;
        if (obs !== expv) begin n_fail++; $display("FAIL unsigned_min: got %h want %h", obs, expv); end
        bus.next_pc = {8'd0, 8'd7, 8'd0, 8'd7};
        run_instr();
        expv = pack(3'd1, 8'd0, 4'b1010, 1'b0);
        n_checks++;
        if (obs !== expv) begin n_fail++; $display("FAIL wrap_literal: got %h want %h", obs, expv); end
    endtask

    task automatic test_fetch_stall();
        launch(3'd3);
        expv = pack(3'd1, 8'd0, 4'b0111, 1'b0);
        n_checks++;
        if (obs !== expv) begin n_fail++; $display("FAIL launch_partial: got %h want %h", obs, expv); end
        bus.fetcher_state = 3'b000;
        bus.start = 1'b1;
        bus.thread_count = 3'd1;
        bus.decoded_mem_write_enable = 1'b1;
        step();
        step();
        n_checks++;
        if (obs !== expv) begin n_fail++; $display("FAIL fetch_hold: got %h want %h", obs, expv); end
        bus.fetcher_state = 3'b010;
        bus.start = 1'b0;
        step();
        expv = pack(3'd2, 8'd0, 4'b0111, 1'b0);
        n_checks++;
        if (obs !== expv) begin n_fail++; $display("FAIL fetch_release: got %h want %h", obs, expv); end
        bus.decoded_mem_write_enable = 1'b0;
    endtask

    task automatic test_lsu_stall();
        bus.next_pc = {4{8'd1}};
        launch(3'd2);
        bus.lsu_state[2] = 2'b01;
        step();
        step();
        step();
        n_checks++;
        if (bus.core_state !== 3'd4) begin n_fail++; $display("FAIL wait_enter: got %0d want 4", bus.core_state); end
        step();
        n_checks++;
        if (bus.core_state !== 3'd5) begin n_fail++; $display("FAIL masked_lane_ignored: got %0d want 5", bus.core_state); end
        step();
        step();
        expv = pack(3'd1, 8'd1, 4'b0011, 1'b0);
        n_checks++;
        if (obs !== expv) begin n_fail++; $display("FAIL lsu_first_instr: got %h want %h", obs, expv); end
        step();
        step();
        step();
        bus.lsu_state[0] = 2'b10;
        for (int k = 0; k < 3; k++) begin
            step();
            n_checks++;
            if (bus.core_state !== 3'd4) begin n_fail++; $display("FAIL wait_hold%0d: got %0d want 4", k, bus.core_state); end
        end
        bus.lsu_state[0] = 2'b00;
        step();
        n_checks++;
        if (bus.core_state !== 3'd5) begin n_fail++; $display("FAIL wait_release: got %0d want 5", bus.core_state); end
        bus.lsu_state = '0;
    endtask

    task automatic test_ret();
        launch(3'd4);
        bus.next_pc = {8'd9, 8'd9, 8'd5, 8'd5};
        run_instr();
        expv = pack(3'd1, 8'd5, 4'b0011, 1'b0);
        n_checks++;
        if (obs !== expv) begin n_fail++; $display("FAIL ret_setup: got %h want %h", obs, expv); end
        bus.decoded_ret = 1'b1;
        run_instr();
        expv = pack(3'd1, 8'd9, 4'b1100, 1'b0);
        n_checks++;
        if (obs !== expv) begin n_fail++; $display("FAIL ret_partial: got %h want %h", obs, expv); end
        run_instr();
        n_checks++;
        if ({bus.core_state, bus.thread_mask, bus.done} !== {3'd7, 4'b0000, 1'b1}) begin
            n_fail++;
            $display("FAIL ret_done: got st=%0d m=%b d=%b want st=7 m=0000 d=1",
                     bus.core_state, bus.thread_mask, bus.done);
        end
        bus.decoded_ret = 1'b0;
        bus.thread_count = 3'd4;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        n_checks++;
        if ({bus.core_state, bus.thread_mask, bus.done} !== {3'd7, 4'b0000, 1'b1}) begin
            n_fail++;
            $display("FAIL done_ignores_start: got st=%0d m=%b d=%b want st=7 m=0000 d=1",
                     bus.core_state, bus.thread_mask, bus.done);
        end
    endtask

    task automatic test_zero_clamp_reset();
        launch(3'd0);
        expv = pack(3'd7, 8'd0, 4'b0000, 1'b1);
        n_checks++;
        if (obs !== expv) begin n_fail++; $display("FAIL zero_count: got %h want %h", obs, expv); end
        step();
        n_checks++;
        if (obs !== expv) begin n_fail++; $display("FAIL zero_count_held: got %h want %h", obs, expv); end
        launch(3'd7);
        expv = pack(3'd1, 8'd0, 4'b1111, 1'b0);
        n_checks++;
        if (obs !== expv) begin n_fail++; $display("FAIL clamp_count: got %h want %h", obs, expv); end
        bus.lsu_state = {4{2'b10}};
        step();
        step();
        step();
        step();
        n_checks++;
        if (bus.core_state !== 3'd4) begin n_fail++; $display("FAIL wait_busy: got %0d want 4", bus.core_state); end
        reset = 1'b1;
        step();
        expv = pack(3'd0, 8'd0, 4'b0000, 1'b0);
        n_checks++;
        if (obs !== expv) begin n_fail++; $display("FAIL reset_in_wait: got %h want %h", obs, expv); end
        reset = 1'b0;
        bus.lsu_state = '0;
    endtask

    initial begin
        reset = 1'b1;
        bus.start = 1'b0;
        bus.thread_count = '0;
        bus.decoded_mem_read_enable = 1'b0;
        bus.decoded_mem_write_enable = 1'b0;
        bus.decoded_ret = 1'b0;
        bus.fetcher_state = 3'b010;
        bus.lsu_state = '0;
        bus.next_pc = '0;
        test_reset();
        test_uniform();
        test_divergence();
        test_fetch_stall();
        test_lsu_stall();
        test_ret();
        test_zero_clamp_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/divergent_scheduler.md
DIVERGENT_SCHEDULER -- requirements
Module: divergent_scheduler

Interface
REQ-001 Parameter THREADS_PER_BLOCK, default 4, number of thread lanes in the core.
REQ-002 Parameter PC_BITS, default 8, program-counter width.
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  launch block; sampled only in IDLE.
REQ-006 thread_count  input  $clog2(THREADS_PER_BLOCK+1)  live threads in block, sampled with start.
REQ-007 decoded_mem_read_enable, decoded_mem_write_enable  input  1 each  decoded control, informational only.
REQ-008 decoded_ret  input  1  current instruction is RET.
REQ-009 fetcher_state  input  3  fetcher state; 3'b010 = FETCHED.
REQ-010 lsu_state  input  [THREADS_PER_BLOCK] x 2  per-lane LSU state; 2'b01 REQUESTING, 2'b10 WAITING.
REQ-011 next_pc  input  [THREADS_PER_BLOCK] x PC_BITS  per-lane PC computed in EXECUTE.
REQ-012 current_pc  output  PC_BITS  PC of instruction being issued.
REQ-013 thread_mask  output  THREADS_PER_BLOCK  lanes executing current instruction.
REQ-014 core_state  output  3  IDLE 000, FETCH 001, DECODE 010, REQUEST 011, WAIT 100, EXECUTE 101, UPDATE 110, DONE 111.
REQ-015 done  output  1  block finished.

Function
REQ-016 Internal state SHALL include per-lane thread_pc[PC_BITS] and alive bit.
REQ-017 IDLE: on start with thread_count>0 -> FETCH; alive[i]=(i<thread_count); thread_pc[i]=0; current_pc=0; thread_mask=alive.
REQ-018 IDLE: on start with thread_count==0 -> DONE, done=1 next cycle.
REQ-019 thread_count above THREADS_PER_BLOCK SHALL be treated as THREADS_PER_BLOCK.
REQ-020 FETCH -> DECODE when fetcher_state==3'b010, else hold.
REQ-021 DECODE -> REQUEST and REQUEST -> WAIT after exactly one cycle each.
REQ-022 WAIT -> EXECUTE when no lane with thread_mask[i]=1 has lsu_state 01 or 10; masked-off lanes ignored.
REQ-023 EXECUTE -> UPDATE after one cycle.
REQ-024 UPDATE, decoded_ret=1: alive[i] cleared for every lane in thread_mask; thread_pc unchanged.
REQ-025 UPDATE, decoded_ret=0: thread_pc[i]<=next_pc[i] for every lane in thread_mask; other lanes unchanged.
REQ-026 UPDATE: using post-update alive/thread_pc, if no lane alive -> DONE with done=1, thread_mask=0; else -> FETCH.
REQ-027 Reconvergence: on leaving UPDATE for FETCH, current_pc = minimum thread_pc over alive lanes; thread_mask = alive lanes whose thread_pc equals that minimum.
REQ-028 PC compare SHALL be unsigned; next_pc wrap-around (e.g. 255->0) is taken literally, no special handling.
REQ-029 Ties: all alive lanes at minimum PC issue together; no lane-index priority.
REQ-030 DONE: all outputs held; start ignored; exit only via reset.
REQ-031 start asserted outside IDLE SHALL be ignored.
REQ-032 decoded_mem_* inputs SHALL NOT affect state transitions.
REQ-033 Cycle cost per instruction with no fetch/LSU stall: 6 cycles FETCH..UPDATE.

Reset
REQ-034 reset SHALL dominate all other inputs in any state, including mid-WAIT.
REQ-035 Reset values: core_state=IDLE, current_pc=0, thread_mask=0, done=0, all alive=0, all thread_pc=0.

Verification
REQ-036 start, thread_count=4, fetcher FETCHED immediately, LSUs idle, next_pc=1 all, decoded_ret=0 -> current_pc=1, thread_mask=4'b1111 after 6 cycles.
REQ-037 Divergence: next_pc={9,5,9,5} (lanes 3..0) -> current_pc=5, mask=0101; those lanes then next_pc=9 -> current_pc=9, mask=1111.
REQ-038 thread_count=2; lane 2 lsu_state=01 in WAIT -> EXECUTE not delayed; lane 0 lsu_state=10 for 3 cycles -> WAIT held 3 extra cycles.
REQ-039 RET with mask 0011 of 1111 -> FETCH with mask 1100; second RET -> DONE, done=1, thread_mask=0.
REQ-040 start with thread_count=0 -> DONE, done=1 one cycle later; reset asserted in WAIT -> IDLE, all outputs 0 next cycle.
